// File: rtl/data_memory_responder.sv
// Multi-cycle data memory for the MEM stage: services load/store after LATENCY cycles.
// Ports: clock/reset, memRead/memWrite/address/write_data in; read_data/ready/error/stall out.
module data_memory_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        error,
  output logic        stall
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = $clog2(LATENCY + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic req;
  logic bad;
  logic commit;

  assign req = memRead | memWrite;

  // Upper address bits must be zero: out-of-range words are rejected,
  // never wrapped into the array.
  assign bad = (memRead & memWrite)
             | (|address[1:0])
             | (|address[31:ADDR_W+2]);

  assign commit = (state_q == BUSY) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = memWrite;
          idx_d   = address[ADDR_W+1:2];
          wdata_d = write_data;
          if (bad) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = DONE;
          if (!we_q) rdata_d = mem[idx_q];
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; a reset mid-access drops the pending store.
  always_ff @(posedge clock) begin
    if (!reset && commit && we_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign read_data = rdata_q;
  assign error     = err_q;
  assign ready     = (state_q == DONE);
  assign stall     = (state_q == BUSY) || ((state_q == IDLE) && req);

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (LATENCY 2, 1 and 15 instances).
// Ports: none; drives three DUTs and prints one summary line.
module tb_data_memory_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        rd   [3];
  logic        wr   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic [31:0] rdata[3];
  logic        rdy  [3];
  logic        err  [3];
  logic        stl  [3];

  data_memory_responder #(.DEPTH(256), .LATENCY(2)) u0 (
    .clock(clk), .reset(reset), .memRead(rd[0]), .memWrite(wr[0]),
    .address(addr[0]), .write_data(wd[0]), .read_data(rdata[0]),
    .ready(rdy[0]), .error(err[0]), .stall(stl[0]));

  data_memory_responder #(.DEPTH(256), .LATENCY(1)) u1 (
    .clock(clk), .reset(reset), .memRead(rd[1]), .memWrite(wr[1]),
    .address(addr[1]), .write_data(wd[1]), .read_data(rdata[1]),
    .ready(rdy[1]), .error(err[1]), .stall(stl[1]));

  data_memory_responder #(.DEPTH(256), .LATENCY(15)) u2 (
    .clock(clk), .reset(reset), .memRead(rd[2]), .memWrite(wr[2]),
    .address(addr[2]), .write_data(wd[2]), .read_data(rdata[2]),
    .ready(rdy[2]), .error(err[2]), .stall(stl[2]));

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rdy[0] === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready rd=%h err=%b", rdata[0], err[0]);
      end else begin
        mon_e = q.pop_front();
        if (rdata[0] !== mon_e.rd || err[0] !== mon_e.er) begin
          fails++;
          $display("FAIL resp got rd=%h err=%b exp rd=%h err=%b",
                   rdata[0], err[0], mon_e.rd, mon_e.er);
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic req(int d, bit r, bit w, logic [31:0] a,
                     logic [31:0] data, logic [31:0] erd, bit eerr,
                     int elat, bit hold, output int rcyc);
    int k;
    int st;
    bit got;
    k = 0;
    st = 0;
    got = 1'b0;
    rcyc = 0;
    if (d == 0) q.push_back(exp_t'{erd, eerr});
    rd[d] = r;
    wr[d] = w;
    addr[d] = a;
    wd[d] = data;
    while (k < 40 && !got) begin
      @(negedge clk);
      if (stl[d]) st++;
      if (rdy[d]) begin
        got = 1'b1;
        rcyc = cyc;
        if (d != 0) begin
          check("rdata", rdata[d], erd);
          check("error", {31'd0, err[d]}, {31'd0, eerr});
        end
      end else begin
        @(posedge clk);
        #1;
        if (!hold) begin
          rd[d] = 1'b0;
          wr[d] = 1'b0;
        end
        k++;
      end
    end
    check("ready_seen", {31'd0, got}, 32'd1);
    check("latency", k, elat);
    check("stall_cycles", st, elat);
    @(posedge clk);
    #1;
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int rc2;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0;
      wr[i] = 1'b0;
      addr[i] = '0;
      wd[i] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_ready", {31'd0, rdy[0]}, 32'd0);
    check("rst_error", {31'd0, err[0]}, 32'd0);
    check("rst_stall", {31'd0, stl[0]}, 32'd0);
    @(posedge clk);
    #1;

    req(0, 0, 1, 32'h20, 32'h0, 32'h0, 0, 3, 0, rc);
    req(0, 0, 1, 32'h04, 32'h0, 32'h0, 0, 3, 0, rc);

    req(0, 0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 3, 0, rc);
    req(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0, rc);

    req(0, 1, 0, 32'h03, 32'h0, 32'h0, 1, 1, 0, rc);
    req(0, 1, 0, 32'h400, 32'h0, 32'h0, 1, 1, 0, rc);
    req(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0, rc);

    req(0, 1, 1, 32'h20, 32'hFFFFFFFF, 32'h0, 1, 1, 0, rc);
    req(0, 1, 0, 32'h20, 32'h0, 32'h0, 0, 3, 0, rc);

    req(0, 0, 1, 32'h08, 32'h11111111, 32'h0, 0, 3, 1, rc);
    req(0, 1, 0, 32'h08, 32'h0, 32'h11111111, 0, 3, 1, rc2);
    check("b2b_gap", rc2 - rc, 4);

    req(0, 0, 1, 32'h04, 32'h0BADF00D, 32'h11111111, 0, 3, 0, rc);
    wr[0] = 1'b1;
    addr[0] = 32'h04;
    wd[0] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    wr[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, rdy[0]}, 32'd0);
    check("abort_stall", {31'd0, stl[0]}, 32'd0);
    check("abort_rdata", rdata[0], 32'd0);
    @(posedge clk);
    #1;
    req(0, 1, 0, 32'h04, 32'h0, 32'h0BADF00D, 0, 3, 0, rc);

    req(1, 0, 1, 32'h0, 32'h12345678, 32'h0, 0, 2, 0, rc);
    req(1, 1, 0, 32'h0, 32'h0, 32'h12345678, 0, 2, 0, rc);
    req(2, 0, 1, 32'h0, 32'h12345678, 32'h0, 0, 16, 0, rc);
    req(2, 1, 0, 32'h0, 32'h0, 32'h12345678, 0, 16, 0, rc);

    check("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
